// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared types and helpers for the sequential multiplier
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add multiplier, one partial product per clock
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int              CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t                 state, state_nxt;
    logic [WIDTH-1:0]       mcand, mplier;
    logic [WIDTH-1:0]       a_mag, b_mag;
    logic [2*WIDTH-1:0]     acc, acc_nxt, partial, result;
    logic [CW-1:0]          cnt;
    logic                   sign_x, signed_r;
    logic                   last;

    assign last = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Magnitudes stay WIDTH bits: the most-negative operand becomes 2^(WIDTH-1) unsigned.
    always_comb begin
        a_mag   = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag   = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        partial = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
        acc_nxt = acc + partial;
        result  = (signed_r && sign_x) ? (~acc_nxt + (2*WIDTH)'(1)) : acc_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            sign_x   <= 1'b0;
            signed_r <= 1'b0;
            product  <= '0;
        end else if (state == IDLE && in_valid) begin
            mcand    <= a_mag;
            mplier   <= b_mag;
            acc      <= '0;
            cnt      <= '0;
            sign_x   <= a[WIDTH-1] ^ b[WIDTH-1];
            signed_r <= is_signed;
        end else if (state == CALC) begin
            acc    <= acc_nxt;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last) begin
                product <= result;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - randomized and directed checks of seq_multiplier at WIDTH 8 and 4
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, is_signed, out_valid, out_ready, busy;
    logic [7:0]  a, b;
    logic [15:0] product;

    logic        in_valid4, in_ready4, is_signed4, out_valid4, out_ready4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  product4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .is_signed(is_signed4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .product(product4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: interpret operands as integers, multiply, keep 2*w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input bit s, input int w);
        longint xv, yv, p;
        longint mask_w, mask_p;
        mask_w = (longint'(1) << w) - 1;
        mask_p = (longint'(1) << (2 * w)) - 1;
        xv = longint'(x) & mask_w;
        yv = longint'(y) & mask_w;
        if (s && x[w-1]) xv = xv - (longint'(1) << w);
        if (s && y[w-1]) yv = yv - (longint'(1) << w);
        p = xv * yv;
        return 64'(p & mask_p);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one operation on the WIDTH=8 unit; junk is driven on the inputs while it computes.
    task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input bit s,
                          input int hold, output logic [15:0] p);
        int          lat;
        bit          calc_bad, hold_bad;
        logic [15:0] p0;
        check("idle_ready", in_ready, 1);
        a = ia; b = ib; is_signed = s; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid  = 1'($urandom_range(0, 1));
        a         = 8'($urandom);
        b         = 8'($urandom);
        is_signed = 1'($urandom_range(0, 1));
        lat = 0;
        calc_bad = 1'b0;
        while (!out_valid && lat < 50) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) calc_bad = 1'b1;
            tick();
            lat++;
        end
        check("latency", 64'(lat), 64'd8);
        check("calc_flags", 64'(calc_bad), 64'd0);
        check("done_flags", {in_ready, busy}, 2'b01);
        p0 = product;
        hold_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (out_valid !== 1'b1 || product !== p0) hold_bad = 1'b1;
        end
        check("hold_stable", 64'(hold_bad), 64'd0);
        p = product;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_ready", {in_ready, out_valid, busy}, 3'b100);
        check("product_kept", product, p);
    endtask

    initial begin
        logic [15:0] p;
        logic [7:0]  ra, rb;
        bit          rs;
        int          n_acc, n_out;
        int          t_out [2];
        logic [7:0]  p4 [2];

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; is_signed4 = 1'b0; out_ready4 = 1'b1;
        tick();
        tick();
        check("rst_flags", {in_ready, out_valid, busy}, 3'b000);
        check("rst_product", product, 16'h0000);
        rst = 1'b0;
        tick();
        check("post_rst_flags", {in_ready, out_valid, busy}, 3'b100);

        issue8(8'hFF, 8'hFF, 1'b0, 0, p);
        check("u_ff_ff", p, 16'hFE01);
        issue8(8'h80, 8'h80, 1'b1, 0, p);
        check("s_m128_sq", p, 16'h4000);
        issue8(8'hFD, 8'h05, 1'b1, 1, p);
        check("s_m3_x5", p, 16'hFFF1);
        issue8(8'hFD, 8'h05, 1'b0, 0, p);
        check("u_fd_x5", p, 16'h04F1);
        issue8(8'h07, 8'h06, 1'b0, 5, p);
        check("backpressure", p, 16'h002A);

        // Abort an operation three cycles into CALC.
        a = 8'h55; b = 8'h33; is_signed = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_flags", {in_ready, out_valid, busy}, 3'b000);
        check("midrst_product", product, 16'h0000);
        rst = 1'b0;
        tick();
        issue8(8'd2, 8'd3, 1'b0, 0, p);
        check("after_rst_2x3", p, 16'd6);

        for (int i = 0; i < 25; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            if (i == 0) ra = 8'h80;
            if (i == 1) rb = 8'h00;
            issue8(ra, rb, rs, int'($urandom_range(0, 3)), p);
            check($sformatf("rand%0d", i), p, ref_mul(32'(ra), 32'(rb), rs, 8));
        end

        // Back-to-back on the WIDTH=4 unit with in_valid held through CALC.
        n_acc = 0;
        n_out = 0;
        t_out[0] = -1; t_out[1] = -1;
        p4[0] = '0; p4[1] = '0;
        in_valid4 = 1'b1; a4 = 4'd15; b4 = 4'd15;
        for (int c = 0; c < 40; c++) begin
            bit acc_now;
            acc_now = in_valid4 && in_ready4;
            tick();
            if (acc_now) begin
                n_acc++;
                if (n_acc == 1) begin
                    a4 = 4'd0; b4 = 4'd9;
                end else begin
                    in_valid4 = 1'b0;
                end
            end
            if (out_valid4 && n_out < 2) begin
                t_out[n_out] = c;
                p4[n_out] = product4;
                n_out++;
            end
        end
        check("b2b_accepts", 64'(n_acc), 64'd2);
        check("b2b_outputs", 64'(n_out), 64'd2);
        check("b2b_first", p4[0], ref_mul(32'd15, 32'd15, 1'b0, 4));
        check("b2b_second", p4[1], ref_mul(32'd0, 32'd9, 1'b0, 4));
        check("b2b_spacing", 64'(t_out[1] - t_out[0]), 64'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised iterative shift-add multiplier with valid/ready handshakes and selectable signed/unsigned operation. It is the area-optimised successor to the combinational 4-bit array multipliers: one partial product per clock, an arbitrary operand width, and a registered full-width product. It serves as a synthesis and optimisation test vehicle and as a drop-in multiply unit for multi-cycle datapaths.

## Interface
- WIDTH, 8, operand width in bits (≥ 2); product is 2*WIDTH bits.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a, b, is_signed are valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- is_signed  in  1  1: a and b are two's complement; 0: unsigned.
- out_valid  out  1  product is valid; high only in DONE.
- out_ready  in  1  consumer accepts product.
- product  out  2*WIDTH  result; two's complement when is_signed was 1.
- busy  out  1  high in CALC or DONE.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. If in_valid, the handshake fires at the clock edge:
  - Capture is_signed.
  - Capture |a| into the multiplicand register and |b| into the multiplier shift register.
  - Capture the result sign as a[MSB]^b[MSB] when is_signed, else 0.
  - Clear the accumulator and bit counter, then go to CALC.
- Magnitudes are held as WIDTH-bit unsigned values. The most-negative value (e.g. -128 at WIDTH=8) maps to 2^(WIDTH-1) without overflow.
- CALC runs for exactly WIDTH cycles. Each cycle:
  - If the multiplier LSB is 1, add the multiplicand, shifted by the counter, into the 2*WIDTH-bit accumulator.
  - Shift the multiplier right by 1 and increment the counter.
- On the last CALC cycle (counter = WIDTH-1):
  - Write the final accumulator value into product, two's-complement negated if the sign bit is set.
  - Go to DONE.
- DONE: out_valid=1 and product is stable. When out_ready is high, go to IDLE.
- No overlap: in_ready is 0 in CALC and DONE, and in_valid is ignored there.
- product holds its last value through IDLE until the next completion overwrites it.
- Arithmetic: the accumulator is 2*WIDTH bits and cannot overflow, since the magnitude product is < 2^(2*WIDTH). The signed result always fits in the 2*WIDTH-bit two's-complement range.

## Timing
- Reset values: in_ready=1 (once out of reset), out_valid=0, busy=0, product=0, state=IDLE, internal registers cleared.
- Reset while rst is high: in_ready=0.
- Reset is honoured from any state, including mid-CALC and DONE with out_ready low. Any in-flight operation is discarded and no out_valid is produced.
- Latency: handshake at edge E. out_valid rises after edge E+WIDTH, i.e. it is visible in the cycle following edge E+WIDTH.
- Latency is constant (WIDTH+1 cycles acceptance-to-valid) regardless of operand values. There is no zero early-out.
- Output handshake at edge F returns the block to IDLE, so in_ready=1 in the next cycle.
- Minimum issue interval is WIDTH+2 cycles with out_ready held high.
- Backpressure: DONE is held indefinitely while out_ready=0, with product unchanged.
- Operand changes after the input handshake have no effect on the result.

## Structure
- Package seq_mult_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - a counter-width function, $clog2(WIDTH).
- Single module, no sub-module. Magnitude and negate logic is inline combinational.

## Test plan
- WIDTH=8, unsigned: a=0xFF, b=0xFF, handshake at edge E -> out_valid in cycle after E+8, product=0xFE01, in_ready low throughout.
- WIDTH=8, signed:
  - a=0x80 (-128), b=0x80 -> product=0x4000.
  - a=0xFD (-3), b=0x05 -> product=0xFFF1 (-15).
  - Same operands unsigned -> 0x04F1.
- Backpressure: complete a=7, b=6 with out_ready=0 for 5 cycles -> out_valid and product=0x002A held stable. One cycle after out_ready rises, in_ready=1.
- Reset mid-CALC: assert rst 3 cycles after acceptance -> next cycle out_valid=0, product=0, busy=0. A following 2*3 request yields 6 with full latency.
- Back-to-back with WIDTH=4: issue 15*15 then 0*9 with out_ready tied high -> products 225 then 0, exactly 6 cycles apart. in_valid asserted during CALC is ignored.
